// File: rtl/microwave_defs.sv
// Shared definitions for the microwave cook-time core: FSM encodings and BCD digit layout.
package microwave_defs;
   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [DIGIT_W-1:0] mt;
      logic [DIGIT_W-1:0] mu;
      logic [DIGIT_W-1:0] st;
      logic [DIGIT_W-1:0] su;
   } mmss_t;
endpackage

// File: rtl/mmss_bcd_counter.sv
// MM:SS BCD register with keypad shift, express load and one-second decrement.
module mmss_bcd_counter
   import microwave_defs::*;
#(
   parameter int unsigned EXPRESS_SEC = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               shift,
   input  logic [DIGIT_W-1:0] shift_digit,
   input  logic               load_express,
   input  logic               decrement,
   output mmss_t              digits,
   output logic               zero_c,
   output logic               dec_zero_c
);
   localparam logic [DIGIT_W-1:0] EXP_ST = DIGIT_W'(EXPRESS_SEC / 10);
   localparam logic [DIGIT_W-1:0] EXP_SU = DIGIT_W'(EXPRESS_SEC % 10);

   mmss_t dec_val;

   // Borrow chain; seconds tens may hold up to 9 from entry (e.g. 00:90).
   always_comb begin
      dec_val = digits;
      if (digits.su != '0) begin
         dec_val.su = digits.su - DIGIT_W'(1);
      end else if (digits.st != '0) begin
         dec_val.st = digits.st - DIGIT_W'(1);
         dec_val.su = DIGIT_W'(9);
      end else if (digits.mu != '0) begin
         dec_val.mu = digits.mu - DIGIT_W'(1);
         dec_val.st = DIGIT_W'(5);
         dec_val.su = DIGIT_W'(9);
      end else if (digits.mt != '0) begin
         dec_val.mt = digits.mt - DIGIT_W'(1);
         dec_val.mu = DIGIT_W'(9);
         dec_val.st = DIGIT_W'(5);
         dec_val.su = DIGIT_W'(9);
      end
   end

   assign zero_c     = (digits == '0);
   assign dec_zero_c = (dec_val == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digits <= '0;
      end else if (clear) begin
         digits <= '0;
      end else if (load_express) begin
         digits <= '{mt: '0, mu: '0, st: EXP_ST, su: EXP_SU};
      end else if (shift) begin
         digits <= '{mt: digits.mu, mu: digits.st, st: digits.su, su: shift_digit};
      end else if (decrement) begin
         digits <= dec_val;
      end
   end
endmodule

// File: rtl/microwave_timer.sv
// Cook-time entry/countdown FSM with one-second prescaler, magnetron enable and done flag.
module microwave_timer
   import microwave_defs::*;
#(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned EXPRESS_SEC = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       start,
   input  logic       stop_clear,
   input  logic       door_closed,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic       mag_on,
   output logic       done
);
   localparam int unsigned       PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);

   state_t           state, state_nxt;
   logic [PRE_W-1:0] pre, pre_nxt;
   logic             clr, shift, load_express, decrement;
   logic             zero_c, dec_zero_c, key_ok, tick;
   mmss_t            digits;

   assign key_ok = key_valid && (key_code <= 4'd9);
   assign tick   = (pre == PRE_MAX);

   mmss_bcd_counter #(.EXPRESS_SEC(EXPRESS_SEC)) u_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clr),
      .shift        (shift),
      .shift_digit  (key_code),
      .load_express (load_express),
      .decrement    (decrement),
      .digits       (digits),
      .zero_c       (zero_c),
      .dec_zero_c   (dec_zero_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         pre    <= '0;
         mag_on <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         pre    <= pre_nxt;
         mag_on <= (state_nxt == COOK);
         done   <= (state_nxt == DONE);
      end
   end

   // Priority stop_clear > start > key in every state.
   always_comb begin
      state_nxt    = state;
      pre_nxt      = pre;
      clr          = 1'b0;
      shift        = 1'b0;
      load_express = 1'b0;
      decrement    = 1'b0;
      case (state)
         IDLE: begin
            if (stop_clear) begin
               state_nxt = IDLE;
            end else if (start) begin
               if (door_closed) begin
                  state_nxt    = COOK;
                  pre_nxt      = '0;
                  load_express = zero_c;
               end
            end else if (key_ok) begin
               shift = 1'b1;
            end
         end
         COOK: begin
            if (stop_clear || !door_closed) begin
               state_nxt = PAUSE;
            end else if (tick) begin
               pre_nxt   = '0;
               decrement = 1'b1;
               if (dec_zero_c) state_nxt = DONE;
            end else begin
               pre_nxt = pre + PRE_W'(1);
            end
         end
         PAUSE: begin
            if (stop_clear) begin
               state_nxt = IDLE;
               clr       = 1'b1;
            end else if (start && door_closed) begin
               state_nxt = COOK;
            end
         end
         DONE: begin
            if (stop_clear || (start && door_closed)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign min_tens  = digits.mt;
   assign min_units = digits.mu;
   assign sec_tens  = digits.st;
   assign sec_units = digits.su;
endmodule

// File: tb/tb_microwave_timer.sv
// Randomized and directed check of microwave_timer against a seconds-arithmetic model.
module tb_microwave_timer;
   localparam int TD = 4;
   localparam int ES = 30;
   localparam int M_IDLE = 0, M_COOK = 1, M_PAUSE = 2, M_DONE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       start = 1'b0;
   logic       stop_clear = 1'b0;
   logic       door_closed = 1'b1;
   logic [3:0] min_tens, min_units, sec_tens, sec_units;
   logic       mag_on, done;

   int n_checks = 0;
   int n_fail   = 0;

   int ms;
   int mpre;
   int mm;
   int ss;

   microwave_timer #(.TICK_DIV(TD), .EXPRESS_SEC(ES)) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
      .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
      .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
      .sec_units(sec_units), .mag_on(mag_on), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] disp();
      return {min_tens, min_units, sec_tens, sec_units};
   endfunction

   // Displayed value: minutes and seconds fields as plain numbers (seconds may be up to 99 from entry).
   function automatic logic [15:0] model_disp();
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic model_reset();
      ms = M_IDLE; mpre = 0; mm = 0; ss = 0;
   endtask

   task automatic model_update();
      case (ms)
         M_IDLE: begin
            if (stop_clear) begin
            end else if (start) begin
               if (door_closed) begin
                  ms = M_COOK; mpre = 0;
                  if (mm == 0 && ss == 0) ss = ES;
               end
            end else if (key_valid && key_code <= 4'd9) begin
               mm = (mm % 10) * 10 + ss / 10;
               ss = (ss % 10) * 10 + int'(key_code);
            end
         end
         M_COOK: begin
            if (stop_clear || !door_closed) begin
               ms = M_PAUSE;
            end else if (mpre == TD - 1) begin
               mpre = 0;
               if (ss > 0) ss--;
               else if (mm > 0) begin mm--; ss = 59; end
               if (mm == 0 && ss == 0) ms = M_DONE;
            end else begin
               mpre++;
            end
         end
         M_PAUSE: begin
            if (stop_clear) begin ms = M_IDLE; mm = 0; ss = 0; end
            else if (start && door_closed) ms = M_COOK;
         end
         default: begin
            if (stop_clear || (start && door_closed)) ms = M_IDLE;
         end
      endcase
   endtask

   task automatic compare_all();
      n_checks++;
      if (disp() !== model_disp() || mag_on !== (ms == M_COOK) || done !== (ms == M_DONE)) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t: got disp=%h mag=%b done=%b, want disp=%h mag=%b done=%b",
                  $time, disp(), mag_on, done, model_disp(), ms == M_COOK, ms == M_DONE);
      end
   endtask

   task automatic lit(input string name, input logic [15:0] ed, input logic em, input logic edn);
      n_checks++;
      if (disp() !== ed || mag_on !== em || done !== edn) begin
         n_fail++;
         $display("FAIL %s: got disp=%h mag=%b done=%b, want disp=%h mag=%b done=%b",
                  name, disp(), mag_on, done, ed, em, edn);
      end
   endtask

   task automatic step(input logic kv, input logic [3:0] kc, input logic st,
                       input logic sc, input logic dr);
      key_valid = kv; key_code = kc; start = st; stop_clear = sc; door_closed = dr;
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask
   task automatic key(input logic [3:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b1); endtask
   task automatic press_start(); step(1'b0, 4'd0, 1'b1, 1'b0, 1'b1); endtask
   task automatic press_stop();  step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1); endtask
   task automatic enter4(input logic [3:0] a, b, c, d);
      key(a); key(b); key(c); key(d);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      lit("reset_state", 16'h0000, 1'b0, 1'b0);

      // Entry, start, first second, key ignored while cooking
      key(4'd1); key(4'd3); key(4'd0);
      lit("entry_0130", 16'h0130, 1'b0, 1'b0);
      press_start();
      lit("start_mag_on", 16'h0130, 1'b1, 1'b0);
      idle(1); key(4'd7); idle(2);
      lit("first_tick_0129", 16'h0129, 1'b1, 1'b0);

      // Async reset mid-COOK
      idle(2);
      #2 rst_n = 1'b0;
      #1 model_reset();
      lit("async_reset", 16'h0000, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(1);
      lit("idle_after_reset", 16'h0000, 1'b0, 1'b0);

      // Minute borrow
      enter4(4'd0, 4'd1, 4'd0, 4'd0);
      press_start(); idle(4);
      lit("borrow_0059", 16'h0059, 1'b1, 1'b0);
      press_stop(); press_stop();
      lit("clear_after_pause", 16'h0000, 1'b0, 1'b0);

      // 00:90 runs 90 seconds to DONE
      enter4(4'd0, 4'd0, 4'd9, 4'd0);
      press_start(); idle(4);
      lit("entry90_0089", 16'h0089, 1'b1, 1'b0);
      idle(4 * 89 - 1);
      lit("before_done", 16'h0001, 1'b1, 1'b0);
      idle(1);
      lit("done_0000", 16'h0000, 1'b0, 1'b1);
      idle(3);
      lit("no_auto_restart", 16'h0000, 1'b0, 1'b1);
      press_stop();
      lit("done_stop_idle", 16'h0000, 1'b0, 1'b0);

      // Express start, invalid key, door-open start
      press_start();
      lit("express_0030", 16'h0030, 1'b1, 1'b0);
      press_stop(); press_stop();
      key(4'hA);
      lit("key_A_ignored", 16'h0000, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      lit("start_door_open", 16'h0000, 1'b0, 1'b0);

      // Door open pause with prescaler at 2, resume
      enter4(4'd0, 4'd0, 4'd4, 4'd5);
      press_start(); idle(2);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      lit("door_pause", 16'h0045, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      press_start();
      lit("resume", 16'h0045, 1'b1, 1'b0);
      idle(1);
      lit("resume_hold", 16'h0045, 1'b1, 1'b0);
      idle(1);
      lit("resume_tick_0044", 16'h0044, 1'b1, 1'b0);

      // stop and start together -> PAUSE
      step(1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      lit("stop_beats_start", 16'h0044, 1'b0, 1'b0);
      press_stop();
      lit("pause_clear", 16'h0000, 1'b0, 1'b0);

      // Randomized phase
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 3) == 0, 4'($urandom_range(0, 15)),
              ($urandom % 12) == 0, ($urandom % 60) == 0, ($urandom % 40) != 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
